// File: rtl/slp_infer_seq.sv
// Single-layer perceptron forward path: serial MAC over N weighted inputs, saturating output.
// Optional bias term enabled by defining SLP_BIAS_EN.

package slp_infer_seq_pkg;
  typedef enum logic {INT, FXP} dfmt_e;
  typedef struct packed {
    dfmt_e       fmt;
    logic        sign;
    int unsigned prec;
    int unsigned frac;
  } dconf_t;
endpackage

module slp_infer_seq import slp_infer_seq_pkg::*; #(
  parameter int unsigned N      = 4,
  parameter dconf_t      I_CONF = dconf_t'{INT, 1'b1, 8, 0},
  parameter dconf_t      W_CONF = dconf_t'{INT, 1'b1, 16, 0},
  parameter dconf_t      P_CONF = dconf_t'{INT, 1'b1, 8, 0},
  localparam int unsigned IW    = I_CONF.prec,
  localparam int unsigned WW    = W_CONF.prec,
  localparam int unsigned PW    = P_CONF.prec,
`ifdef SLP_BIAS_EN
  localparam int unsigned IDXW  = $clog2(N + 1)
`else
  localparam int unsigned IDXW  = $clog2(N)
`endif
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            w_we,
  input  logic [IDXW-1:0] w_idx,
  input  logic [WW-1:0]   w_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PW-1:0]   pred,
  output logic            ovf,
  output logic            udf,
  output logic            rounded
);

  localparam int unsigned AW   = IW + WW + $clog2(N);
  localparam int unsigned CW   = AW + 1;  // headroom for the optional bias term
  localparam int unsigned CNTW = $clog2(N);
  localparam int          SI   = int'(I_CONF.frac) + int'(W_CONF.frac) - int'(P_CONF.frac);
  localparam int unsigned SH   = (SI < 0) ? 0 : SI;
  localparam bit          ACC_SIGNED = I_CONF.sign || W_CONF.sign;

  localparam logic [CW-1:0] RMASK = (CW'(1) << SH) - CW'(1);
  localparam logic signed [CW-1:0] PMAX =
    P_CONF.sign ? ((CW'(1) << (PW - 1)) - CW'(1)) : ((CW'(1) << PW) - CW'(1));
  localparam logic signed [CW-1:0] PMIN = P_CONF.sign ? -(CW'(1) << (PW - 1)) : '0;

  if (SI < 0) begin : g_bad_shift
    $error("slp_infer_seq: prediction has more fraction bits than in*weight");
  end

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e          state;
  logic [CNTW-1:0] cnt;
  logic [AW-1:0]   acc;
  logic [WW-1:0]   w_q [N];
`ifdef SLP_BIAS_EN
  logic [WW-1:0]   bias_q;
`endif

  logic [AW-1:0]          in_ext, w_ext, prod, acc_nxt;
  logic signed [CW-1:0]   sum, shr;
  logic [PW-1:0]          p_d;
  logic                   ovf_d, udf_d, rnd_d;

  always_comb begin
    in_ext  = I_CONF.sign ? AW'(signed'(in)) : AW'(in);
    w_ext   = W_CONF.sign ? AW'(signed'(w_q[cnt])) : AW'(w_q[cnt]);
    prod    = in_ext * w_ext;
    acc_nxt = acc + prod;
    sum     = ACC_SIGNED ? CW'(signed'(acc_nxt)) : CW'(acc_nxt);
`ifdef SLP_BIAS_EN
    sum     = sum + ((W_CONF.sign ? CW'(signed'(bias_q)) : CW'(bias_q)) << I_CONF.frac);
`endif
    shr     = sum >>> SH;
    rnd_d   = |(sum & RMASK);
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    if (shr > PMAX) begin
      p_d   = PMAX[PW-1:0];
      ovf_d = 1'b1;
    end else if (shr < PMIN) begin
      p_d   = PMIN[PW-1:0];
      udf_d = 1'b1;
    end else begin
      p_d   = shr[PW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state     <= StIdle;
      cnt       <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      pred      <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      rounded   <= 1'b0;
      for (int i = 0; i < int'(N); i++) w_q[i] <= '0;
`ifdef SLP_BIAS_EN
      bias_q    <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          state    <= StAcc;
          acc      <= '0;
          cnt      <= '0;
          in_ready <= 1'b1;
        end
        StAcc: begin
          if (in_valid && in_ready) begin
            acc <= acc_nxt;
            if (cnt == CNTW'(N - 1)) begin
              state     <= StOut;
              cnt       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              pred      <= p_d;
              ovf       <= ovf_d;
              udf       <= udf_d;
              rounded   <= rnd_d;
            end else begin
              cnt <= cnt + CNTW'(1);
            end
          end
        end
        StOut: begin
          if (out_ready) begin
            state     <= StAcc;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
      // Nonblocking write after the MAC read gives read-before-write on the same index.
      if (w_we && (32'(w_idx) < N)) w_q[w_idx] <= w_data;
`ifdef SLP_BIAS_EN
      if (w_we && (32'(w_idx) == N)) bias_q <= w_data;
`endif
    end
  end

endmodule
